// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the plane-shooter game sequencer.
//   state_e     : 2-bit FSM encoding (IDLE=0, PLAY=1, BOSS=2, OVER=3)
//   LIVES_W     : width of the lives counter
//   FRAME_CNT_W : width of the frame down-counter
package game_pkg;

   localparam int LIVES_W     = 3;
   localparam int FRAME_CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_BOSS = 2'd2,
      ST_OVER = 2'd3
   } state_e;

endpackage

// File: rtl/game_ctrl_frame_timer.sv
// frame_timer: vsync falling-edge detector plus a loadable frame down-counter.
// Ports:
//   clk_i, rst_i   : pixel clock, synchronous active-high reset
//   vsync_i        : VGA vsync (active-low pulse)
//   load_i         : load the counter with load_val_i (wins over counting)
//   load_val_i     : value to load, in frames
//   freeze_i       : hold the counter on frame ticks
//   frame_tick_o   : one-cycle pulse on the falling edge of registered vsync
//   zero_o         : counter value after this cycle's update is zero
module frame_timer
   import game_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   vsync_i,
   input  logic                   load_i,
   input  logic [FRAME_CNT_W-1:0] load_val_i,
   input  logic                   freeze_i,
   output logic                   frame_tick_o,
   output logic                   zero_o
);

   logic                   vs_q, vs_qq;
   logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;

   assign frame_tick_o = vs_qq & ~vs_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (frame_tick_o && !freeze_i && cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   // Looking at the next value lets the owner act on the very tick that
   // brings the count to zero, not one cycle later.
   assign zero_o = (cnt_d == '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vs_q  <= 1'b1;   // vsync idles high
         vs_qq <= 1'b1;
         cnt_q <= '0;
      end else begin
         vs_q  <= vsync_i;
         vs_qq <= vs_q;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: game sequencer for the VGA plane shooter (start screen, play,
// boss phase, game over). Tracks lives and score, times invulnerability and
// the game-over hold in video frames, and pulses round_rst for one cycle at
// round start.
// Ports:
//   clk, rst                     : pixel clock, synchronous active-high reset
//   enter                        : enter key level (rising edge acts)
//   boom, enemy_kill, boss_kill  : event pulses from the sprite judges
//   vsync                        : VGA vsync, active low
//   play_en/boss_en/game_over    : decoded from state
//   move_en                      : sprite movement enable
//   invuln, round_rst, win       : registered status
//   lives, score, state          : counters and current FSM state
// Optional feature macro: GAME_PAUSE_EN (enter toggles pause in PLAY/BOSS).
module game_ctrl
   import game_pkg::*;
#(
   parameter int LIVES_INIT    = 3,
   parameter int SCORE_W       = 16,
   parameter int BOSS_SCORE    = 50,
   parameter int BOSS_PTS      = 10,
   parameter int INVULN_FRAMES = 120,
   parameter int OVER_FRAMES   = 180
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enter,
   input  logic               boom,
   input  logic               enemy_kill,
   input  logic               boss_kill,
   input  logic               vsync,
   output logic               play_en,
   output logic               boss_en,
   output logic               move_en,
   output logic               invuln,
   output logic               round_rst,
   output logic               game_over,
   output logic               win,
   output logic [LIVES_W-1:0] lives,
   output logic [SCORE_W-1:0] score,
   output logic [1:0]         state
);

   localparam int SW1 = SCORE_W + 1;
   localparam logic [SCORE_W-1:0] BOSS_SCORE_V = SCORE_W'(BOSS_SCORE);
   localparam logic [LIVES_W-1:0] LIVES_INIT_V = LIVES_W'(LIVES_INIT);

   state_e               state_q;
   logic [LIVES_W-1:0]   lives_q;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [SW1-1:0]       score_sum;
   logic                 invuln_q, round_rst_q, win_q, enter_q;
   logic                 paused;
   logic                 enter_rise, in_game, act, hit, fatal, boss_win, to_over;
   logic                 tm_load, tm_zero, frame_tick, expire;
   logic [FRAME_CNT_W-1:0] tm_val;

`ifdef GAME_PAUSE_EN
   logic paused_q;
   assign paused = paused_q;
`else
   assign paused = 1'b0;
`endif

   assign enter_rise = enter & ~enter_q;
   assign in_game    = (state_q == ST_PLAY) || (state_q == ST_BOSS);
   assign act        = in_game & ~paused;
   assign hit        = act & boom & ~invuln_q;
   assign fatal      = hit & (lives_q == LIVES_W'(1));
   // a fatal boom in the same cycle as a boss kill is scored as a loss
   assign boss_win   = act & (state_q == ST_BOSS) & boss_kill & ~fatal;
   assign to_over    = fatal | boss_win;
   assign tm_load    = hit | boss_win;
   assign tm_val     = to_over ? FRAME_CNT_W'(OVER_FRAMES) : FRAME_CNT_W'(INVULN_FRAMES);
   assign expire     = frame_tick & tm_zero & ~paused;

   // both kill sources may land in the same cycle; saturate at all-ones
   always_comb begin
      score_sum = {1'b0, score_q} + SW1'(enemy_kill)
                + ((state_q == ST_BOSS && boss_kill) ? SW1'(BOSS_PTS) : '0);
      score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
   end

   frame_timer u_timer (
      .clk_i        (clk),
      .rst_i        (rst),
      .vsync_i      (vsync),
      .load_i       (tm_load),
      .load_val_i   (tm_val),
      .freeze_i     (paused),
      .frame_tick_o (frame_tick),
      .zero_o       (tm_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         lives_q     <= LIVES_INIT_V;
         score_q     <= '0;
         invuln_q    <= 1'b0;
         round_rst_q <= 1'b0;
         win_q       <= 1'b0;
         enter_q     <= 1'b0;
`ifdef GAME_PAUSE_EN
         paused_q    <= 1'b0;
`endif
      end else begin
         enter_q     <= enter;
         round_rst_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (enter_rise) begin
                  state_q     <= ST_PLAY;
                  lives_q     <= LIVES_INIT_V;
                  score_q     <= '0;
                  win_q       <= 1'b0;
                  invuln_q    <= 1'b0;
                  round_rst_q <= 1'b1;
               end
            end
            ST_PLAY, ST_BOSS: begin
               if (act) begin
                  score_q <= score_d;
                  if (invuln_q && expire)
                     invuln_q <= 1'b0;
                  if (hit) begin
                     lives_q  <= lives_q - 1'b1;
                     invuln_q <= ~fatal;
                  end
                  if (fatal) begin
                     state_q <= ST_OVER;
                     win_q   <= 1'b0;
                  end else if (boss_win) begin
                     state_q  <= ST_OVER;
                     win_q    <= 1'b1;
                     invuln_q <= 1'b0;
                  end else if (state_q == ST_PLAY && score_q >= BOSS_SCORE_V) begin
                     state_q <= ST_BOSS;
                  end
               end
`ifdef GAME_PAUSE_EN
               if (to_over)
                  paused_q <= 1'b0;
               else if (enter_rise)
                  paused_q <= ~paused_q;
`endif
            end
            ST_OVER: begin
               if (expire || enter_rise)
                  state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign play_en   = (state_q != ST_IDLE);
   assign boss_en   = (state_q == ST_BOSS);
   assign game_over = (state_q == ST_OVER);
   assign move_en   = ~paused;
   assign invuln    = invuln_q;
   assign round_rst = round_rst_q;
   assign win       = win_q;
   assign lives     = lives_q;
   assign score     = score_q;
   assign state     = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: a vector table for round start and early
// play, then hand-written sequences for frame timing, boss phase, game over,
// saturation (on a narrow-score instance) and mid-game reset.
module tb_game_ctrl;

   logic clk = 1'b0;
   logic rst, enter, boom, ek, bk, vsync, ek2, bk2;

   logic play_en, boss_en, move_en, invuln, round_rst, game_over, win;
   logic [2:0]  lives;
   logic [15:0] score;
   logic [1:0]  state;

   logic play_en2, boss_en2, move_en2, invuln2, round_rst2, game_over2, win2;
   logic [2:0] lives2;
   logic [5:0] score2;
   logic [1:0] state2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   game_ctrl dut (
      .clk(clk), .rst(rst), .enter(enter), .boom(boom), .enemy_kill(ek),
      .boss_kill(bk), .vsync(vsync), .play_en(play_en), .boss_en(boss_en),
      .move_en(move_en), .invuln(invuln), .round_rst(round_rst),
      .game_over(game_over), .win(win), .lives(lives), .score(score),
      .state(state)
   );

   // narrow score so saturation is reachable in a few dozen kills
   game_ctrl #(.SCORE_W(6)) dut2 (
      .clk(clk), .rst(rst), .enter(enter), .boom(boom), .enemy_kill(ek2),
      .boss_kill(bk2), .vsync(vsync), .play_en(play_en2), .boss_en(boss_en2),
      .move_en(move_en2), .invuln(invuln2), .round_rst(round_rst2),
      .game_over(game_over2), .win(win2), .lives(lives2), .score(score2),
      .state(state2)
   );

   typedef struct {
      logic        en, bm, k, b;
      logic [1:0]  st;
      logic [2:0]  lv;
      logic [15:0] sc;
      logic        rr, inv;
   } vec_t;

   vec_t tv[11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one video frame: vsync low one cycle, high three; its tick is consumed inside
   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         vsync = 1'b0; tick();
         vsync = 1'b1; tick(); tick(); tick();
      end
   endtask

   task automatic rst_pulse();
      rst = 1'b1; tick(); rst = 1'b0;
   endtask

   task automatic start();
      enter = 1'b1; tick(); enter = 1'b0; tick();
   endtask

   task automatic kills(input int n);
      ek = 1'b1;
      repeat (n) tick();
      ek = 1'b0;
   endtask

   task automatic hit();
      boom = 1'b1; tick(); boom = 1'b0;
   endtask

   initial begin
      rst = 1'b1; enter = 0; boom = 0; ek = 0; bk = 0; ek2 = 0; bk2 = 0; vsync = 1'b1;
      tick(); tick();
      chk("rst_state", state, 0);
      chk("rst_lives", lives, 3);
      chk("rst_score", score, 0);
      chk("rst_move_en", move_en, 1);
      chk("rst_round_rst", round_rst, 0);
      chk("rst_win", win, 0);
      chk("rst_invuln", invuln, 0);
      chk("rst_play_en", play_en, 0);
      rst = 1'b0;

      // ---- table: round start, enter held, kills and booms in PLAY
      //           en bm k  b  st lv sc rr inv
      tv[0]  = '{0, 1, 1, 0, 0, 3, 0, 0, 0};   // pulses ignored in IDLE
      tv[1]  = '{1, 0, 0, 0, 1, 3, 0, 1, 0};   // rise -> PLAY, round_rst
      tv[2]  = '{1, 0, 0, 0, 1, 3, 0, 0, 0};   // held: no second pulse
      tv[3]  = '{1, 0, 0, 0, 1, 3, 0, 0, 0};
      tv[4]  = '{1, 0, 0, 0, 1, 3, 0, 0, 0};
      tv[5]  = '{1, 0, 0, 0, 1, 3, 0, 0, 0};
      tv[6]  = '{0, 0, 1, 0, 1, 3, 1, 0, 0};
      tv[7]  = '{0, 0, 1, 1, 1, 3, 2, 0, 0};   // boss_kill ignored in PLAY
      tv[8]  = '{0, 1, 0, 0, 1, 2, 2, 0, 1};   // first hit
      tv[9]  = '{0, 1, 0, 0, 1, 2, 2, 0, 1};   // invulnerable: ignored
      tv[10] = '{0, 0, 1, 0, 1, 2, 3, 0, 1};
      for (int i = 0; i < 11; i++) begin
         enter = tv[i].en; boom = tv[i].bm; ek = tv[i].k; bk = tv[i].b;
         tick();
         chk($sformatf("tv%0d_state", i), state, tv[i].st);
         chk($sformatf("tv%0d_lives", i), lives, tv[i].lv);
         chk($sformatf("tv%0d_score", i), score, tv[i].sc);
         chk($sformatf("tv%0d_round_rst", i), round_rst, tv[i].rr);
         chk($sformatf("tv%0d_invuln", i), invuln, tv[i].inv);
      end
      enter = 0; boom = 0; ek = 0; bk = 0;

      // ---- invulnerability lasts exactly 120 frames; a boom at frame 10 is ignored
      frames(10);
      hit();
      chk("inv_boom_ignored", lives, 2);
      frames(109);
      chk("inv_at_119", invuln, 1);
      frames(1);
      chk("inv_at_120", invuln, 0);
      hit();
      chk("inv_rehit_lives", lives, 1);
      chk("inv_rehit_inv", invuln, 1);

      // ---- boss threshold and boss win
      rst_pulse(); start();
      kills(49);
      chk("k49_score", score, 49);
      chk("k49_state", state, 1);
      kills(1);
      chk("k50_score", score, 50);
      chk("k50_state", state, 1);
      tick();
      chk("boss_state", state, 2);
      chk("boss_en", boss_en, 1);
      bk = 1'b1; tick(); bk = 1'b0;
      chk("bwin_score", score, 60);
      chk("bwin_state", state, 3);
      chk("bwin_win", win, 1);
      chk("bwin_game_over", game_over, 1);
      chk("bwin_play_en", play_en, 1);
      kills(1);
      chk("over_kill_ignored", score, 60);
      enter = 1'b1; tick(); enter = 1'b0;
      chk("over_enter_idle", state, 0);
      chk("over_enter_play_en", play_en, 0);
      tick();

      // ---- out of lives, then 180-frame hold back to IDLE
      rst_pulse(); start();
      hit();
      chk("l_lives2", lives, 2);
      frames(120);
      hit();
      chk("l_lives1", lives, 1);
      frames(120);
      chk("l_inv_clear", invuln, 0);
      hit();
      chk("l_lives0", lives, 0);
      chk("l_state_over", state, 3);
      chk("l_win0", win, 0);
      chk("l_game_over", game_over, 1);
      frames(179);
      chk("l_hold_179", state, 3);
      chk("l_hold_lives", lives, 0);
      frames(1);
      chk("l_idle_180", state, 0);

      // ---- simultaneous kills in BOSS: +11 and win
      rst_pulse(); start();
      kills(50); tick();
      chk("sim_boss", state, 2);
      ek = 1'b1; bk = 1'b1; tick(); ek = 1'b0; bk = 1'b0;
      chk("sim_score", score, 61);
      chk("sim_state", state, 3);
      chk("sim_win", win, 1);

      // ---- boss kill together with fatal boom is a loss
      rst_pulse(); start();
      kills(50); tick();
      hit(); frames(120);
      hit(); frames(120);
      chk("tie_lives1", lives, 1);
      chk("tie_boss", state, 2);
      boom = 1'b1; bk = 1'b1; tick(); boom = 1'b0; bk = 1'b0;
      chk("tie_state", state, 3);
      chk("tie_win", win, 0);
      chk("tie_lives0", lives, 0);

      // ---- saturation on the 6-bit instance
      rst_pulse(); start();
      ek2 = 1'b1;
      repeat (62) tick();
      chk("sat_62", score2, 62);
      tick();
      chk("sat_63", score2, 63);
      tick();
      chk("sat_hold", score2, 63);
      bk2 = 1'b1; tick(); ek2 = 1'b0; bk2 = 1'b0;
      chk("sat_boss", score2, 63);
      chk("sat_win", win2, 1);
      chk("sat_state", state2, 3);

      // ---- reset in BOSS
      rst_pulse(); start();
      kills(50); tick();
      chk("mr_boss", state, 2);
      rst = 1'b1; tick();
      chk("mr_state", state, 0);
      chk("mr_score", score, 0);
      chk("mr_lives", lives, 3);
      chk("mr_round_rst", round_rst, 0);
      rst = 1'b0; tick();
      chk("mr_no_pulse", round_rst, 0);

      // ---- enter inside PLAY
      start();
      enter = 1'b1; tick(); enter = 1'b0;
`ifdef GAME_PAUSE_EN
      chk("pz_move_off", move_en, 0);
      kills(1);
      chk("pz_kill_ignored", score, 0);
      hit();
      chk("pz_boom_ignored", lives, 3);
      enter = 1'b1; tick(); enter = 1'b0;
      chk("pz_move_on", move_en, 1);
      kills(1);
      chk("pz_kill_counts", score, 1);
`else
      chk("np_move_en", move_en, 1);
      chk("np_state", state, 1);
      kills(1);
      chk("np_kill_counts", score, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
